// File: rtl/encode_branch_pkg.sv
// instr_type: shared branch-kind, encoder error and opcode definitions.
package instr_type;
  typedef enum logic [2:0] {
    bk_invalid = 3'd0, bk_beq, bk_bne, bk_blt, bk_bge, bk_bltu, bk_bgeu
  } branch_kind_t;
  typedef enum logic [1:0] {ee_none = 2'd0, ee_kind, ee_align, ee_range} enc_err_t;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int ENC_PAYLOAD_W = 34;
  // Returns {mapped, funct3}; mapped = 0 for bk_invalid and unused encodings.
  function automatic logic [3:0] funct3_of(branch_kind_t k);
    return k == bk_beq  ? 4'b1000 :
           k == bk_bne  ? 4'b1001 :
           k == bk_blt  ? 4'b1100 :
           k == bk_bge  ? 4'b1101 :
           k == bk_bltu ? 4'b1110 :
           k == bk_bgeu ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/encode_branch_if.sv
// encode_branch_if: request and result handshakes of the branch encoder.
interface encode_branch_if;
  import instr_type::*;
  logic         in_valid;
  logic         in_ready;
  branch_kind_t in_kind;
  logic [4:0]   in_rs1;
  logic [4:0]   in_rs2;
  logic [31:0]  in_offset;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_instr;
  enc_err_t     out_err;
  modport master (
    output in_valid, in_kind, in_rs1, in_rs2, in_offset, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
  modport slave (
    input  in_valid, in_kind, in_rs1, in_rs2, in_offset, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/enc_fifo2.sv
// enc_fifo2: 2-entry in-order synchronous FIFO, no bypass.
module enc_fifo2 #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wptr_q, rptr_q;
  logic [1:0]   count_q, count_d;
  logic         push, pop;
  always_comb begin
    full_o  = count_q[1];
    empty_o = count_q == 2'd0;
    push    = push_i & ~full_o;
    pop     = pop_i & ~empty_o;
    count_d = count_q + 2'(push) - 2'(pop);
    rdata_o = mem_q[rptr_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) mem_q[wptr_q] <= wdata_i;
      wptr_q  <= wptr_q ^ push;
      rptr_q  <= rptr_q ^ pop;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/encode_branch.sv
// encode_branch: RV32I B-type branch encoder with error codes and a 2-entry output buffer.
module encode_branch
  import instr_type::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  encode_branch_if.slave       bus,
  output logic [ERR_CNT_W-1:0] err_count
);
  logic [3:0]               f3v;
  logic                     in_range;
  enc_err_t                 err;
  logic [31:0]              instr;
  logic                     accept, full, empty;
  logic [ENC_PAYLOAD_W-1:0] rdata;
  logic [ERR_CNT_W-1:0]     err_count_q, err_count_d;
  always_comb begin
    f3v      = funct3_of(bus.in_kind);
    in_range = &bus.in_offset[31:12] | ~|bus.in_offset[31:12];
    err      = !f3v[3]          ? ee_kind  :
               bus.in_offset[0] ? ee_align :
               !in_range        ? ee_range : ee_none;
    instr    = err != ee_none ? 32'h0 :
               {bus.in_offset[12], bus.in_offset[10:5], bus.in_rs2, bus.in_rs1,
                f3v[2:0], bus.in_offset[4:1], bus.in_offset[11], OPC_BRANCH};
    // in_ready depends only on buffer occupancy, never on out_ready.
    bus.in_ready  = ~rst & ~full;
    accept        = bus.in_valid & bus.in_ready;
    err_count_d   = (accept && err != ee_none && !(&err_count_q)) ?
                    err_count_q + ERR_CNT_W'(1) : err_count_q;
    bus.out_valid = ~empty;
    bus.out_instr = rdata[33:2];
    bus.out_err   = enc_err_t'(rdata[1:0]);
    err_count     = err_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end
  enc_fifo2 #(.W(ENC_PAYLOAD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (bus.out_ready),
    .wdata_i ({instr, err}),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_encode_branch.sv
// tb_encode_branch: directed test of encode_branch against a queue-based reference model.
module tb_encode_branch;
  import instr_type::*;
  localparam int CW = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] err_count;
  int            checks = 0;
  int            errors = 0;
  logic [33:0]   mq [$];
  int            mcnt = 0;
  logic          m_push, m_pop;
  logic [33:0]   m_e;
  encode_branch_if bus ();
  encode_branch #(.ERR_CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus), .err_count(err_count));
  always #5 clk = ~clk;
  function automatic logic [33:0] model_enc(branch_kind_t k, logic [4:0] r1, logic [4:0] r2, logic [31:0] off);
    int f3;
    int o;
    logic [31:0] w;
    o = $signed(off);
    case (k)
      bk_beq:  f3 = 0;
      bk_bne:  f3 = 1;
      bk_blt:  f3 = 4;
      bk_bge:  f3 = 5;
      bk_bltu: f3 = 6;
      bk_bgeu: f3 = 7;
      default: f3 = -1;
    endcase
    if (f3 < 0) return {32'h0, ee_kind};
    if (o % 2 != 0) return {32'h0, ee_align};
    if (o < -4096 || o > 4094) return {32'h0, ee_range};
    w = {off[12], off[10:5], r2, r1, 3'(f3), off[4:1], off[11], 7'b1100011};
    return {w, ee_none};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      m_push = bus.in_valid && mq.size() < 2;
      m_pop  = bus.out_ready && mq.size() > 0;
      m_e    = model_enc(bus.in_kind, bus.in_rs1, bus.in_rs2, bus.in_offset);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(m_e);
        if (m_e[1:0] != ee_none && mcnt < (1 << CW) - 1) mcnt++;
      end
    end
  end
  always @(negedge clk) begin
    check("in_ready", bus.in_ready, 32'(!rst && mq.size() < 2));
    check("out_valid", bus.out_valid, 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("out_instr", bus.out_instr, mq[0][33:2]);
      check("out_err", 32'(bus.out_err), 32'(mq[0][1:0]));
    end
    check("err_count", 32'(err_count), mcnt);
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic send(branch_kind_t k, logic [4:0] r1, logic [4:0] r2, logic [31:0] off);
    logic rdy;
    bus.in_valid  = 1'b1;
    bus.in_kind   = k;
    bus.in_rs1    = r1;
    bus.in_rs2    = r2;
    bus.in_offset = off;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      sync();
      if (rdy) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: request not accepted within 40 cycles");
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_kind   = bk_beq;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_offset = '0;
    bus.out_ready = 1'b1;
    sync();
    sync();
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_err", 32'(bus.out_err), 32'(ee_none));
    check("rst_in_ready", bus.in_ready, 0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);
    sync();
    send(bk_beq, 5'd1, 5'd2, 32'd8);
    @(negedge clk);
    check("beq_valid", bus.out_valid, 1);
    check("beq_instr", bus.out_instr, 32'h00208463);
    check("beq_err", 32'(bus.out_err), 32'(ee_none));
    sync();
    send(bk_bne, 5'd0, 5'd0, -32'sd4);
    @(negedge clk);
    check("bne_instr", bus.out_instr, 32'hFE001EE3);
    sync();
    send(bk_blt, 5'd3, 5'd4, 32'd4094);
    @(negedge clk);
    check("max_err", 32'(bus.out_err), 32'(ee_none));
    check("max_bit31", bus.out_instr[31], 0);
    check("max_bit7", bus.out_instr[7], 1);
    sync();
    send(bk_bgeu, 5'd5, 5'd6, -32'sd4096);
    @(negedge clk);
    check("min_err", 32'(bus.out_err), 32'(ee_none));
    check("min_bit31", bus.out_instr[31], 1);
    check("min_bit7", bus.out_instr[7], 0);
    sync();
    send(bk_bge, 5'd1, 5'd1, 32'd4096);
    @(negedge clk);
    check("range_err", 32'(bus.out_err), 32'(ee_range));
    check("range_instr", bus.out_instr, 0);
    sync();
    send(bk_bltu, 5'd1, 5'd1, 32'd3);
    @(negedge clk);
    check("align_err", 32'(bus.out_err), 32'(ee_align));
    sync();
    send(bk_invalid, 5'd1, 5'd1, 32'd3);
    @(negedge clk);
    check("kind_err", 32'(bus.out_err), 32'(ee_kind));
    check("kind_instr", bus.out_instr, 0);
    check("err_count_3", 32'(err_count), 3);
    sync();
    send(branch_kind_t'(3'd7), 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    check("unmapped_err", 32'(bus.out_err), 32'(ee_kind));
    sync();
    bus.out_ready = 1'b0;
    send(bk_beq, 5'd1, 5'd2, 32'd8);
    send(bk_bne, 5'd3, 5'd4, 32'd12);
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    sync();
    fork
      send(bk_beq, 5'd7, 5'd8, 32'd16);
      begin
        sync();
        sync();
        sync();
        bus.out_ready = 1'b1;
      end
    join
    repeat (4) sync();
    bus.out_ready = 1'b0;
    send(bk_bne, 5'd9, 5'd10, 32'd32);
    bus.out_ready = 1'b1;
    send(bk_blt, 5'd11, 5'd12, -32'sd32);
    @(negedge clk);
    check("pushpop_valid", bus.out_valid, 1);
    check("pushpop_head", bus.out_instr, 32'hFEC5C0E3);
    sync();
    @(negedge clk);
    check("pushpop_drained", bus.out_valid, 0);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    send(bk_beq, 5'd0, 5'd0, 32'd1);
    send(bk_beq, 5'd0, 5'd0, 32'd8192);
    @(negedge clk);
    check("sat_err_count_2", 32'(err_count), 2);
    sync();
    for (int i = 0; i < 3; i++) send(bk_invalid, 5'd0, 5'd0, 32'd0);
    @(negedge clk);
    check("sat_err_count_hold", 32'(err_count), 3);
    sync();
    bus.out_ready = 1'b0;
    send(bk_bge, 5'd2, 5'd3, 32'd5);
    send(bk_bge, 5'd2, 5'd3, 32'd6);
    bus.in_valid  = 1'b1;
    bus.in_kind   = bk_beq;
    bus.in_offset = 32'd20;
    rst = 1'b1;
    sync();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_err_count", 32'(err_count), 0);
    repeat (2) sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/encode_branch.md
# encode_branch

Branch-instruction encoder: the inverse of the branch decode path. It accepts a branch kind, two source register indices and a signed byte offset. It emits the 32-bit RV32I B-type instruction word, or an error code when the request cannot be encoded. Sits in the test/assembly side of the core (instruction generator, self-check harness) and feeds a stream consumer through a valid/ready output backed by a 2-entry buffer.

## Interface

- ERR_CNT_W, 16, width of saturating error counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept a request this cycle
- in_kind  in  branch_kind_t  requested branch kind
- in_rs1  in  5  source register 1 index
- in_rs2  in  5  source register 2 index
- in_offset  in  32  signed byte offset, two's complement
- out_valid  out  1  encoded result present
- out_ready  in  1  consumer accepts result this cycle
- out_instr  out  32  encoded instruction word; 32'h0 when out_err != ee_none
- out_err  out  enc_err_t  error code for the presented result
- err_count  out  ERR_CNT_W  number of accepted erroneous requests, saturating

## Operation

- Input handshake: a request is accepted on a rising edge where in_valid && in_ready.
- Output handshake: a result is consumed on a rising edge where out_valid && out_ready.
- Encoding is combinational from the inputs and is written into the buffer on acceptance.
- funct3 mapping:
  - bk_beq 000
  - bk_bne 001
  - bk_blt 100
  - bk_bge 101
  - bk_bltu 110
  - bk_bgeu 111
- Word layout:
  - [31] = off[12], [30:25] = off[10:5]
  - [24:20] = rs2, [19:15] = rs1, [14:12] = funct3
  - [11:8] = off[4:1], [7] = off[11]
  - [6:0] = 7'b1100011
- Error checks, in priority order (first hit wins):
  - ee_kind: in_kind is bk_invalid or any unmapped value.
  - ee_align: in_offset[0] = 1.
  - ee_range: in_offset outside [-4096, 4094], i.e. bits [31:12] are not all equal.
  - Otherwise ee_none.
- On any error, out_instr = 32'h0 and err_count increments by 1 at acceptance. Once it reaches all-ones it holds.
- Buffer: 2-entry FIFO, in order. in_ready = (count < 2). No combinational path from out_ready to in_ready.
- Simultaneous push and pop:
  - count 1: count stays 1, old entry leaves, new entry becomes head.
  - count 0: the push lands and out_valid rises next cycle. No bypass.
- out_instr and out_err show the head entry. Both hold stable while out_valid && !out_ready.

## Timing

- Latency: request accepted at edge N gives out_valid = 1 after edge N (visible cycle N+1) when the buffer was empty.
- Throughput: 1 request/cycle while out_ready stays high.
- Reset, while rst = 1 at an edge:
  - count = 0
  - out_valid = 0, out_instr = 0, out_err = ee_none
  - err_count = 0
  - in_ready = 0 while rst is high; it is 1 in the first cycle after rst falls.
- Reset mid-operation: buffered entries are dropped with no output and no counter change. A request presented during the rst-high cycle is not accepted.
- Full (count 2): in_ready = 0. in_valid is ignored, and the request must be held by the producer.
- Empty (count 0): out_valid = 0. out_ready is ignored.

## Structure

- Add to shared package instr_type:
  - enc_err_t: 2-bit enum {ee_none = 0, ee_kind = 1, ee_align = 2, ee_range = 3}
  - OPC_BRANCH = 7'b1100011
- branch_kind_t is reused from instr_type unchanged.
- One sub-module: enc_fifo2, a 2-entry synchronous FIFO parameterised on payload width (32 + 2 bits). It owns count, read/write pointers and the full/empty flags.
- Encoding, error priority and err_count live in encode_branch.

## Test plan

- Reset, then bk_beq, rs1 = 1, rs2 = 2, offset = 8, out_ready = 1.
  - Expect out_valid at cycle N+1, out_instr = 32'h00208463, out_err = ee_none.
- bk_bne, rs1 = 0, rs2 = 0, offset = -4.
  - Expect out_instr = 32'hFE001EE3.
  - Then offset = 4094 and offset = -4096 both give ee_none; check bits [31] and [7] against the layout.
- Offset errors, each giving out_instr = 0:
  - offset 4096 → ee_range
  - offset 3 → ee_align
  - bk_invalid with offset 3 → ee_kind
  - Expect err_count = 3.
- out_ready = 0 while streaming 3 valid requests.
  - in_ready falls after 2 acceptances and the third request is held.
  - Raising out_ready drains the results in order; the third request is accepted on the first pop cycle.
- With 1 entry buffered, push and pop on the same edge.
  - count stays 1, the next head is the new request, and no result is lost or duplicated.
- Force err_count to all-ones minus 1 (ERR_CNT_W = 2), then send 3 erroneous requests.
  - err_count = 3 and holds.
  - Asserting rst mid-stream clears out_valid and err_count on the next edge.
